// File: rtl/mod_reduce_serial_pkg.sv
// Shared definitions for the bit-serial modular reducer.
//   N_DEFAULT  : operand / modulus width (product is 2*N_DEFAULT bits)
//   CW_DEFAULT : iteration counter width, 2**CW_DEFAULT > 2*N_DEFAULT
//   state_e    : controller state encoding
package mod_reduce_serial_pkg;

  localparam int unsigned N_DEFAULT  = 224;
  localparam int unsigned CW_DEFAULT = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mod_reduce_serial_if.sv
// Start/done request bundle for mod_reduce_serial.
//   start : request (master -> slave)
//   c     : 2N-bit product to reduce (master -> slave)
//   m     : N-bit modulus (master -> slave)
//   busy  : reduction in progress (slave -> master)
//   done  : one-cycle completion pulse (slave -> master)
//   r     : registered remainder (slave -> master)
interface mod_reduce_serial_if
  import mod_reduce_serial_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
);

  logic             start;
  logic [2*N-1:0]   c;
  logic [N-1:0]     m;
  logic             busy;
  logic             done;
  logic [N-1:0]     r;

  modport master (output start, c, m, input busy, done, r);
  modport slave  (input start, c, m, output busy, done, r);

endinterface

// File: rtl/mod_reduce_step.sv
// One restoring-reduction iteration: shift one product bit into the
// partial remainder and subtract the modulus if the result reaches it.
//   r_i   : current remainder (always < m_i, so N bits suffice)
//   bit_i : next product bit, MSB first
//   m_i   : modulus; m_i == 0 forces the remainder to zero
//   r_o   : next remainder
module mod_reduce_step
  import mod_reduce_serial_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic [N-1:0] r_i,
  input  logic         bit_i,
  input  logic [N-1:0] m_i,
  output logic [N-1:0] r_o
);

  logic [N:0] t;

  always_comb begin
    t   = {r_i, bit_i};
    r_o = t[N-1:0];
    if (m_i == '0) begin
      r_o = '0;
    end else if (t >= {1'b0, m_i}) begin
      // True difference is < m_i < 2**N, so modulo-2**N arithmetic on the
      // low bits yields it exactly; t[N] only matters for the compare.
      r_o = t[N-1:0] - m_i;
    end
  end

endmodule

// File: rtl/mod_reduce_serial.sv
// Bit-serial restoring reduction r = c mod m, one product bit per clock.
// A job accepted in IDLE spends exactly 2N edges in RUN, one edge in DONE,
// then pulses done with r updated; r holds until the next completion.
//   clk : rising-edge clock
//   rst : synchronous active-low reset (aborts any job, no done)
//   bus : slave side of mod_reduce_serial_if (start/c/m in, busy/done/r out)
module mod_reduce_serial
  import mod_reduce_serial_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned CW = CW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  mod_reduce_serial_if.slave   bus
);

  localparam logic [CW-1:0] LAST_CNT = CW'(2*N - 1);

  state_e          state_q;
  logic            busy_q;
  logic            done_q;
  logic [N-1:0]    r_q;
  // Partial remainder kept at N bits: R < M holds between iterations,
  // so the extra bit only exists transiently inside the step.
  logic [N-1:0]    rem_q;
  logic [N-1:0]    rem_d;
  logic [2*N-1:0]  c_q;
  logic [N-1:0]    m_q;
  logic [CW-1:0]   cnt_q;

  mod_reduce_step #(.N(N)) u_step (
    .r_i   (rem_q),
    .bit_i (c_q[2*N-1]),
    .m_i   (m_q),
    .r_o   (rem_d)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      rem_q   <= '0;
      c_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            c_q     <= bus.c;
            m_q     <= bus.m;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          c_q   <= {c_q[2*N-2:0], 1'b0};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          r_q     <= rem_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.r    = r_q;

endmodule

// File: tb/tb_mod_reduce_serial.sv
module tb_mod_reduce_serial;

  localparam int unsigned N  = 224;
  localparam int unsigned CW = 9;

  typedef logic [2*N-1:0] wide_t;
  typedef logic [N-1:0]   nar_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mod_reduce_serial_if #(.N(N)) bus ();

  mod_reduce_serial #(.N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  nar_t        exp_q[$];

  task automatic check(input string tag, input wide_t obs, input wide_t exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts edges (sampled #1 after each posedge) until done, bounded.
  // busy_cnt includes the sample taken on entry (just after acceptance).
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = (bus.busy === 1'b1) ? 1 : 0;
    while (edges < 1000) begin
      @(posedge clk); #1;
      edges++;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) return;
    end
  endtask

  task automatic launch(input wide_t c, input nar_t m, input nar_t exp);
    bus.start = 1'b1;
    bus.c     = c;
    bus.m     = m;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.c     = ~c;   // inputs may change freely after acceptance
    bus.m     = ~m;
  endtask

  task automatic finish_job(input string tag, input bit chk_timing);
    int   edges;
    int   bcnt;
    nar_t exp;
    wait_done(edges, bcnt);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    if (chk_timing) begin
      check({tag, "_latency"}, wide_t'(edges), wide_t'(449));
      check({tag, "_busy_cycles"}, wide_t'(bcnt), wide_t'(448));
    end
    check({tag, "_r"}, wide_t'(bus.r), wide_t'(exp));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, wide_t'(bus.done), wide_t'(0));
    check({tag, "_r_hold"}, wide_t'(bus.r), wide_t'(exp));
  endtask

  initial begin
    wide_t w;
    nar_t  mv;
    int    edges;
    int    bcnt;
    int    dones;

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.c     = '0;
    bus.m     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", wide_t'(bus.busy), wide_t'(0));
    check("reset_done", wide_t'(bus.done), wide_t'(0));
    check("reset_r", wide_t'(bus.r), wide_t'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    // basic: 100 mod 7
    launch(wide_t'(100), nar_t'(7), nar_t'(2));
    check("accept_busy", wide_t'(bus.busy), wide_t'(1));
    finish_job("m7", 1'b1);

    // m = 2^224-3, c = m*m -> 0
    mv = '1;
    mv = mv - nar_t'(2);
    w  = wide_t'(mv) * wide_t'(mv);
    launch(w, mv, nar_t'(0));
    finish_job("msq", 1'b1);

    // c = 2^224 -> 3
    w    = '0;
    w[N] = 1'b1;
    launch(w, mv, nar_t'(3));
    finish_job("p224", 1'b1);

    // c = 2^448-1, m = 2^224-1 -> 0
    w  = '1;
    mv = '1;
    launch(w, mv, nar_t'(0));
    finish_job("allones", 1'b1);

    // c < m
    launch(wide_t'(12345), mv, nar_t'(12345));
    finish_job("c_lt_m", 1'b1);

    // m = 0 -> 0, normal latency
    w        = '0;
    w[2*N-1] = 1'b1;
    w        = w + wide_t'(5);
    launch(w, nar_t'(0), nar_t'(0));
    finish_job("m0", 1'b1);

    // m = 1 -> 0
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    launch(w, nar_t'(1), nar_t'(0));
    finish_job("m1", 1'b1);

    // back-to-back with start held high; c changes during RUN
    bus.start = 1'b1;
    bus.c     = wide_t'(100);
    bus.m     = nar_t'(7);
    exp_q.push_back(nar_t'(2));
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1;
    bus.c = wide_t'(1000);
    exp_q.push_back(nar_t'(6));     // 1000 mod 7
    wait_done(edges, bcnt);
    check("b2b_first_r", wide_t'(bus.r), wide_t'(exp_q.pop_front()));
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_second_accept", wide_t'(bus.busy), wide_t'(1));
    wait_done(edges, bcnt);
    check("b2b_done_spacing", wide_t'(edges + 1), wide_t'(450));
    check("b2b_second_r", wide_t'(bus.r), wide_t'(exp_q.pop_front()));
    @(posedge clk); #1;

    // reset aborts a running job
    bus.start = 1'b1;
    bus.c     = wide_t'(100);
    bus.m     = nar_t'(7);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("abort_busy", wide_t'(bus.busy), wide_t'(0));
    check("abort_r", wide_t'(bus.r), wide_t'(0));
    check("abort_done", wide_t'(bus.done), wide_t'(0));
    dones = 0;
    repeat (500) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) dones++;
    end
    check("abort_no_done", wide_t'(dones), wide_t'(0));

    launch(wide_t'(100), nar_t'(7), nar_t'(2));
    finish_job("after_abort", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
